// File: rtl/vga_scanout.sv
// -----------------------------------------------------------------------------
// vga_scanout
//
// Scan-out stage for a 160x120, 8 bpp (RGB332) frame buffer. It generates VGA
// timing (640x480@60 by default) from the system clock. It drives the frame
// buffer read coordinates with 2^SCALE_SHIFT pixel and line replication. It
// turns the returned pixel data into colour outputs that are aligned with sync.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-low reset (release taken synchronously)
//   pixelData   frame-buffer read data, RGB332, combinational in x_data/y_data
//   x_data      frame-buffer read column (screen h >> SCALE_SHIFT)
//   y_data      frame-buffer read row    (screen v >> SCALE_SHIFT)
//   vga_r/g/b   colour outputs, forced to zero outside the visible area
//   hsync       horizontal sync, active-low
//   vsync       vertical sync, active-low
//   vblank      high while the output stage shows a line >= V_ACTIVE
//   frame_done  one-clk pulse when the last visible pixel reaches the outputs
// -----------------------------------------------------------------------------
module vga_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int CLK_DIV     = 2,
    parameter int SCALE_SHIFT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pixelData,
    output logic [7:0] x_data,
    output logic [7:0] y_data,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [1:0] vga_b,
    output logic       hsync,
    output logic       vsync,
    output logic       vblank,
    output logic       frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_p0;
    logic          pix_en;
    logic [HW-1:0] h_p0;
    logic [VW-1:0] v_p0;

    logic          act_c, hs_c, vs_c, vb_c, last_c;
    logic          act_p1, hs_p1, vs_p1, vb_p1, last_p1;

    // With CLK_DIV=1 the divider never leaves 0, so pix_en stays high.
    assign pix_en = (div_p0 == DW'(CLK_DIV - 1));

    // ---- stage 0: pixel divider and raster counters ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_p0 <= '0;
            h_p0   <= '0;
            v_p0   <= '0;
        end else begin
            if (pix_en) begin
                div_p0 <= '0;
                if (h_p0 == HW'(H_TOTAL - 1)) begin
                    h_p0 <= '0;
                    if (v_p0 == VW'(V_TOTAL - 1)) begin
                        v_p0 <= '0;
                    end else begin
                        v_p0 <= v_p0 + VW'(1);
                    end
                end else begin
                    h_p0 <= h_p0 + HW'(1);
                end
            end else begin
                div_p0 <= div_p0 + DW'(1);
            end
        end
    end

    always_comb begin
        act_c  = (h_p0 < HW'(H_ACTIVE)) && (v_p0 < VW'(V_ACTIVE));
        hs_c   = !((h_p0 >= HW'(H_ACTIVE + H_FP)) &&
                   (h_p0 <  HW'(H_ACTIVE + H_FP + H_SYNC)));
        vs_c   = !((v_p0 >= VW'(V_ACTIVE + V_FP)) &&
                   (v_p0 <  VW'(V_ACTIVE + V_FP + V_SYNC)));
        vb_c   = (v_p0 >= VW'(V_ACTIVE));
        last_c = (h_p0 == HW'(H_ACTIVE - 1)) && (v_p0 == VW'(V_ACTIVE - 1));
    end

    // ---- stage 1: frame-buffer address and per-pixel flags ----
    // Coordinates past 159/119 during blanking are harmless: colour is masked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_data  <= '0;
            y_data  <= '0;
            act_p1  <= 1'b0;
            hs_p1   <= 1'b1;
            vs_p1   <= 1'b1;
            vb_p1   <= 1'b0;
            last_p1 <= 1'b0;
        end else if (pix_en) begin
            x_data  <= 8'(h_p0 >> SCALE_SHIFT);
            y_data  <= 8'(v_p0 >> SCALE_SHIFT);
            act_p1  <= act_c;
            hs_p1   <= hs_c;
            vs_p1   <= vs_c;
            vb_p1   <= vb_c;
            last_p1 <= last_c;
        end
    end

    // ---- stage 2: colour sample and output sync ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_r      <= '0;
            vga_g      <= '0;
            vga_b      <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            vblank     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (pix_en) begin
                {vga_r, vga_g, vga_b} <= act_p1 ? pixelData : 8'd0;
                hsync  <= hs_p1;
                vsync  <= vs_p1;
                vblank <= vb_p1;
            end
            // Only the tick that moves last_p1 into the outputs raises it,
            // so the pulse is one clk wide whatever CLK_DIV is.
            frame_done <= pix_en && last_p1;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
module tb_vga_scanout;

    // Reduced raster so several whole frames fit in a short run.
    localparam int HA = 32, HFP = 4, HS = 6, HBP = 6;
    localparam int VA = 16, VFP = 2, VS = 2, VBP = 3;
    localparam int SS = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        logic       vb;
        logic       fd;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] x0, y0, x1, y1, pix0, pix1;
    logic [2:0] r0, g0, r1, g1;
    logic [1:0] b0, b1;
    logic       hs0, vs0, vb0, fd0, hs1, vs1, vb1, fd1;
    obs_t       obs0, obs1;

    // Frame-buffer model: the pixel value is column XOR row.
    assign pix0 = x0 ^ y0;
    assign pix1 = x1 ^ y1;
    assign obs0 = {x0, y0, r0, g0, b0, hs0, vs0, vb0, fd0};
    assign obs1 = {x1, y1, r1, g1, b1, hs1, vs1, vb1, fd1};

    vga_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                  .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                  .CLK_DIV(2), .SCALE_SHIFT(SS)) u_div2 (
        .clk(clk), .rst(rst), .pixelData(pix0), .x_data(x0), .y_data(y0),
        .vga_r(r0), .vga_g(g0), .vga_b(b0), .hsync(hs0), .vsync(vs0),
        .vblank(vb0), .frame_done(fd0));

    vga_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                  .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                  .CLK_DIV(1), .SCALE_SHIFT(SS)) u_div1 (
        .clk(clk), .rst(rst), .pixelData(pix1), .x_data(x1), .y_data(y1),
        .vga_r(r1), .vga_g(g1), .vga_b(b1), .hsync(hs1), .vsync(vs1),
        .vblank(vb1), .frame_done(fd1));

    int   n_cmp = 0;
    int   n_bad = 0;
    int   c = 0;       // clk edges since reset release
    int   cyc = 0;     // free-running negedge count for interval checks
    logic meas_en = 1'b0;
    obs_t q0[$];
    obs_t q1[$];

    // Expected outputs after cc clocks since release. Tick t is the t-th pixel
    // tick; the address stage shows raster position t-1 and the colour/sync
    // stage shows position t-2, positions counting row-major modulo a frame.
    function automatic obs_t model(input int cc, input int div);
        obs_t o;
        int   t, q, h, v;
        o    = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        t    = cc / div;
        if (t >= 1) begin
            q   = (t - 1) % FT;
            h   = q % HT;
            v   = q / HT;
            o.x = 8'(h >> SS);
            o.y = 8'(v >> SS);
        end
        if (t >= 2) begin
            q = (t - 2) % FT;
            h = q % HT;
            v = q / HT;
            if (h < HA && v < VA) o.rgb = 8'((h >> SS) ^ (v >> SS));
            o.hs = !(h >= HA + HFP && h < HA + HFP + HS);
            o.vs = !(v >= VA + VFP && v < VA + VFP + VS);
            o.vb = (v >= VA);
            o.fd = (cc % div == 0) && (h == HA - 1) && (v == VA - 1);
        end
        return o;
    endfunction

    task automatic check(input string nm, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s c=%0d: got x=%0d y=%0d rgb=%02h hs=%b vs=%b vb=%b fd=%b, want x=%0d y=%0d rgb=%02h hs=%b vs=%b vb=%b fd=%b",
                     nm, c, act.x, act.y, act.rgb, act.hs, act.vs, act.vb, act.fd,
                     exp.x, exp.y, exp.rgb, exp.hs, exp.vs, exp.vb, exp.fd);
        end
    endtask

    // Generator: one expectation per clock for each build.
    always @(posedge clk) begin
        if (!rst) c = 0;
        else      c = c + 1;
        q0.push_back(model(c, 2));
        q1.push_back(model(c, 1));
    end

    // Monitor: compare each presented output set against the queued expectation.
    always @(negedge clk) begin
        if (q0.size() > 0) check("scan_div2", obs0, q0.pop_front());
        if (q1.size() > 0) check("scan_div1", obs1, q1.pop_front());
    end

    // Interval checks on an uninterrupted run: period between assertions and
    // assertion width for hsync low, vsync low, vblank and frame_done.
    logic prev_s[8];
    int   st[8];

    task automatic track(input string nm, input int idx, input logic s,
                         input int per, input int wid);
        if (s && !prev_s[idx]) begin
            if (st[idx] >= 0) begin
                n_cmp++;
                if (cyc - st[idx] != per) begin
                    n_bad++;
                    $display("FAIL %s_period: got %0d clk, want %0d", nm, cyc - st[idx], per);
                end
            end
            st[idx] = cyc;
        end
        if (!s && prev_s[idx] && st[idx] >= 0) begin
            n_cmp++;
            if (cyc - st[idx] != wid) begin
                n_bad++;
                $display("FAIL %s_width: got %0d clk, want %0d", nm, cyc - st[idx], wid);
            end
        end
        prev_s[idx] = s;
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (meas_en) begin
            track("hsync_div2",  0, !hs0, HT * 2,  HS * 2);
            track("vsync_div2",  1, !vs0, FT * 2,  VS * HT * 2);
            track("vblank_div2", 2, vb0,  FT * 2,  (VT - VA) * HT * 2);
            track("fdone_div2",  3, fd0,  FT * 2,  1);
            track("hsync_div1",  4, !hs1, HT,      HS);
            track("vsync_div1",  5, !vs1, FT,      VS * HT);
            track("vblank_div1", 6, vb1,  FT,      (VT - VA) * HT);
            track("fdone_div1",  7, fd1,  FT,      1);
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            prev_s[i] = 1'b0;
            st[i]     = -1;
        end
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Random-length runs, each cut short by an asynchronous reset.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2 rst = 1'b1;
            repeat ($urandom_range(200, 2600)) @(posedge clk);
            @(negedge clk);
            #2 rst = 1'b0;
            #1;
            check("async_rst_div2", obs0, model(0, 2));
            check("async_rst_div1", obs1, model(0, 1));
            repeat ($urandom_range(1, 4)) @(posedge clk);
        end

        // Long uninterrupted run covering several frames for interval checks.
        @(negedge clk);
        #2 rst = 1'b1;
        meas_en = 1'b1;
        repeat (2 * FT * 2 + 300) @(posedge clk);
        @(negedge clk);
        meas_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Video scan-out stage downstream of the 160×120, 8 bpp frame buffer. Generates 640×480@60 Hz VGA timing from the system clock, drives the frame buffer's read coordinates (`x_data`, `y_data`) with 4× pixel/line replication, and samples the returned `pixelData` into RGB332 outputs with matching sync. Also provides a vertical-blank flag and an end-of-frame pulse so the drawing side can time buffer updates.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixel ticks)
- `H_SYNC`, 96: horizontal sync width
- `H_BP`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vertical sync width
- `V_BP`, 33: vertical back porch
- `CLK_DIV`, 2: `clk` cycles per pixel tick (≥1)
- `SCALE_SHIFT`, 2: log2 of the replication factor (screen coordinate >> `SCALE_SHIFT` = frame-buffer coordinate)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `pixelData`  in  8  frame-buffer read data, RGB332 (`[7:5]` R, `[4:2]` G, `[1:0]` B); combinational function of `x_data`/`y_data`
- `x_data`  out  8  frame-buffer read column
- `y_data`  out  8  frame-buffer read row
- `vga_r`  out  3  red
- `vga_g`  out  3  green
- `vga_b`  out  2  blue
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `vblank`  out  1  high while the output stage is on a line ≥ `V_ACTIVE`
- `frame_done`  out  1  one-`clk` pulse when the last visible pixel of a frame leaves the output stage

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider `div` counts 0..CLK_DIV-1; `pix_en` = (`div` == CLK_DIV-1). CLK_DIV=1 → `pix_en` constantly high.
- On `pix_en`: `h` increments; at H_TOTAL-1 it wraps to 0 and `v` increments; `v` wraps from V_TOTAL-1 to 0 on the same tick.
- Stage A (registered on `pix_en`): `x_data` = h>>SCALE_SHIFT, `y_data` = v>>SCALE_SHIFT (truncated to 8 bits; in blanking these exceed 159/119, which is legal); `act_a` = (h<H_ACTIVE && v<V_ACTIVE); `hs_a` = !(H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC); `vs_a` likewise on `v`; `vb_a` = (v ≥ V_ACTIVE); `last_a` = (h==H_ACTIVE-1 && v==V_ACTIVE-1).
- Stage B (registered on `pix_en`): {`vga_r`,`vga_g`,`vga_b`} = `act_a` ? `pixelData` : 0; `hsync`←`hs_a`; `vsync`←`vs_a`; `vblank`←`vb_a`.
- `frame_done`: high for exactly one `clk` on the `pix_en` edge that loads `last_a` into stage B; low otherwise.
- Outputs hold between `pix_en` ticks.
- Replication: each frame-buffer pixel is shown for 2^SCALE_SHIFT consecutive ticks and on 2^SCALE_SHIFT consecutive lines.

## Timing
- Reset (async assert, `rst`=0): `div`, `h`, `v`, `x_data`, `y_data` = 0; RGB = 0; `hsync`=`vsync`=1; `vblank`=0; `frame_done`=0; stage-A flags cleared (act=0, hs=vs=1).
- Reset release is taken synchronously; first `pix_en` occurs CLK_DIV `clk` edges after release.
- Latency: counter state → stage-B outputs = 2 pixel ticks; sync, colour, `vblank` and `frame_done` share identical alignment.
- `pixelData` is sampled once per tick at the `pix_en` edge, one tick after `x_data`/`y_data` change.
- Mid-frame reset: all outputs return to reset values immediately; scan restarts at (0,0) — no partial-frame completion, no `frame_done`.
- hsync period = H_TOTAL ticks, low H_SYNC ticks; vsync low V_SYNC×H_TOTAL ticks, period V_TOTAL×H_TOTAL ticks.

## Test plan
- Reset: hold `rst`=0 for 5 clk -> RGB=0, `hsync`=`vsync`=1, `x_data`=`y_data`=0, `vblank`=0; assert `rst` mid-line -> outputs reset asynchronously within the same cycle.
- Horizontal timing (CLK_DIV=2): `hsync` low 192 clk, period 1600 clk; first falling edge 2×(656+2)=1316 clk after release.
- Vertical timing: `vsync` low 3200 clk, period 840000 clk; `vblank` high 45×1600 = 72000 clk per frame.
- Pixel path: bench model `pixelData` = `x_data` ^ `y_data`; screen (h=8,v=4) -> fb (2,1) -> 0x03 -> r=0,g=0,b=3; same value on h=8..11, lines 4..7; any blanking position -> RGB=0.
- `frame_done`: exactly one 1-clk pulse per 840000 clk, coincident with the output-stage update for screen pixel (639,479).
- CLK_DIV=1 build: `hsync` period 800 clk, `pix_en` constant, pixel check above still passes.
